// File: rtl/reg_dump_reader.sv
// Register-bank dump controller: walks a contiguous range of register addresses, captures each
// read value and streams (index, data) words out over a valid/ready handshake.
module reg_dump_reader #(
   parameter int unsigned NUM_REGS  = 32,
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 5
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic              abort_i,
   output logic [ADDR_W-1:0] rd_addr_o,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic [ADDR_W-1:0] out_index_o,
   output logic              busy_o,
   output logic              done_o
);

   typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

   localparam logic [ADDR_W-1:0] FirstIdx = ADDR_W'(FIRST_REG);
   localparam logic [ADDR_W-1:0] LastIdx  = ADDR_W'(FIRST_REG + NUM_REGS - 1);

   state_e              state_q;
   logic [ADDR_W-1:0]   cnt_q;
   logic [ADDR_W-1:0]   rd_addr_q;
   logic                out_valid_q;
   logic [DATA_W-1:0]   out_data_q;
   logic [ADDR_W-1:0]   out_index_q;
   logic                done_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         done_q      <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (abort_i) begin
            // A word still waiting for the sink is dropped, and no completion is signalled.
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (start_i) begin
                     state_q   <= StRead;
                     cnt_q     <= FirstIdx;
                     rd_addr_q <= FirstIdx;
                  end
               end
               StRead: begin
                  out_data_q  <= rd_data_i;
                  out_index_q <= cnt_q;
                  out_valid_q <= 1'b1;
                  state_q     <= StSend;
               end
               StSend: begin
                  if (out_ready_i) begin
                     out_valid_q <= 1'b0;
                     // Compare before incrementing so a full 32-entry walk never wraps.
                     if (cnt_q == LastIdx) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end else begin
                        cnt_q     <= cnt_q + 1'b1;
                        rd_addr_q <= cnt_q + 1'b1;
                        state_q   <= StRead;
                     end
                  end
               end
               StDone: begin
                  state_q <= StIdle;
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign busy_o      = (state_q == StRead) || (state_q == StSend);
   assign rd_addr_o   = rd_addr_q;
   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_index_o = out_index_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a default full-range instance and a FIRST_REG=8,
// NUM_REGS=4 instance share one modelled register bank.
module tb_reg_dump_reader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] bank [32];

   logic        start_a = 1'b0, abort_a = 1'b0, out_ready_a = 1'b0;
   logic [4:0]  rd_addr_a, out_index_a;
   logic [31:0] rd_data_a, out_data_a;
   logic        out_valid_a, busy_a, done_a;

   logic        start_b = 1'b0, abort_b = 1'b0, out_ready_b = 1'b1;
   logic [4:0]  rd_addr_b, out_index_b;
   logic [31:0] rd_data_b, out_data_b;
   logic        out_valid_b, busy_b, done_b;

   int n_cmp = 0;
   int n_err = 0;
   int done_cnt_a = 0;
   int done_cnt_b = 0;
   int words_b = 0;
   logic [36:0] exp_a [$];
   logic [36:0] exp_b [$];

   assign rd_data_a = bank[rd_addr_a];
   assign rd_data_b = bank[rd_addr_b];

   always #5 clk = ~clk;

   reg_dump_reader u_dut_a (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start_a),
      .abort_i     (abort_a),
      .rd_addr_o   (rd_addr_a),
      .rd_data_i   (rd_data_a),
      .out_valid_o (out_valid_a),
      .out_ready_i (out_ready_a),
      .out_data_o  (out_data_a),
      .out_index_o (out_index_a),
      .busy_o      (busy_a),
      .done_o      (done_a)
   );

   reg_dump_reader #(
      .NUM_REGS  (4),
      .FIRST_REG (8)
   ) u_dut_b (
      .clk_i       (clk),
      .reset_i     (reset),
      .start_i     (start_b),
      .abort_i     (abort_b),
      .rd_addr_o   (rd_addr_b),
      .rd_data_i   (rd_data_b),
      .out_valid_o (out_valid_b),
      .out_ready_i (out_ready_b),
      .out_data_o  (out_data_b),
      .out_index_o (out_index_b),
      .busy_o      (busy_b),
      .done_o      (done_b)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out waiting for DUT", name);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] reg_val(input int i);
      return (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
   endfunction

   task automatic push_a(input int first, input int last);
      for (int i = first; i <= last; i++) exp_a.push_back({5'(i), reg_val(i)});
   endtask

   task automatic wait_word_a(input int idx, input string name);
      bit found = 0;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (out_valid_a && out_index_a == 5'(idx)) begin
            found = 1;
            break;
         end
      end
      if (!found) timeout_fail(name);
   endtask

   task automatic wait_done_a(input string name);
      bit found = 0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (done_a) begin
            found = 1;
            break;
         end
      end
      if (!found) timeout_fail(name);
   endtask

   // Monitors: a word is consumed at the edge following a negedge that sees valid && ready.
   always @(negedge clk) begin
      if (!reset && out_valid_a && out_ready_a) begin
         if (exp_a.size() == 0) begin
            timeout_fail("a_unexpected_word");
         end else begin
            logic [36:0] e;
            e = exp_a.pop_front();
            check("a_index", 64'(out_index_a), 64'(e[36:32]));
            check("a_data", 64'(out_data_a), 64'(e[31:0]));
         end
      end
      if (!reset && done_a) done_cnt_a++;
   end

   always @(negedge clk) begin
      if (!reset && out_valid_b && out_ready_b) begin
         words_b++;
         if (exp_b.size() == 0) begin
            timeout_fail("b_unexpected_word");
         end else begin
            logic [36:0] e;
            e = exp_b.pop_front();
            check("b_index", 64'(out_index_b), 64'(e[36:32]));
            check("b_data", 64'(out_data_b), 64'(e[31:0]));
         end
      end
      if (!reset && done_b) done_cnt_b++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) bank[i] = reg_val(i);

      // Reset state
      #2;
      check("rst_valid", 64'(out_valid_a), 64'h0);
      check("rst_busy", 64'(busy_a), 64'h0);
      check("rst_done", 64'(done_a), 64'h0);
      check("rst_rd_addr", 64'(rd_addr_a), 64'h0);
      check("rst_data", 64'(out_data_a), 64'h0);
      check("rst_index", 64'(out_index_a), 64'h0);
      tick();
      reset = 1'b0;
      tick();

      // Full dump with the sink always ready: cycle-exact valid/busy/done pattern
      out_ready_a = 1'b1;
      done_cnt_a  = 0;
      push_a(0, 31);
      start_a = 1'b1;
      for (int c = 1; c <= 66; c++) begin
         tick();
         if (c == 1) start_a = 1'b0;
         check($sformatf("full_busy_c%0d", c), 64'(busy_a), 64'(c <= 64));
         check($sformatf("full_valid_c%0d", c), 64'(out_valid_a), 64'((c % 2 == 0) && c <= 64));
         check($sformatf("full_done_c%0d", c), 64'(done_a), 64'(c == 65));
      end
      check("full_words_left", 64'(exp_a.size()), 64'h0);
      check("full_done_count", 64'(done_cnt_a), 64'h1);

      // Backpressure on reg3
      done_cnt_a = 0;
      push_a(0, 31);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_word_a(3, "bp_wait_reg3");
      out_ready_a = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("bp_valid_%0d", k), 64'(out_valid_a), 64'h1);
         check($sformatf("bp_data_%0d", k), 64'(out_data_a), 64'h1000_0003);
         check($sformatf("bp_index_%0d", k), 64'(out_index_a), 64'h3);
         tick();
      end
      out_ready_a = 1'b1;
      wait_done_a("bp_wait_done");
      tick();
      check("bp_words_left", 64'(exp_a.size()), 64'h0);
      check("bp_done_count", 64'(done_cnt_a), 64'h1);

      // Abort while word 10 is presented and unaccepted
      done_cnt_a = 0;
      push_a(0, 9);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_word_a(9, "abort_wait_reg9");
      wait_word_a(10, "abort_wait_reg10");
      out_ready_a = 1'b0;
      abort_a     = 1'b1;
      tick();
      abort_a = 1'b0;
      check("abort_valid", 64'(out_valid_a), 64'h0);
      check("abort_busy", 64'(busy_a), 64'h0);
      check("abort_done", 64'(done_a), 64'h0);
      for (int k = 0; k < 4; k++) tick();
      check("abort_done_count", 64'(done_cnt_a), 64'h0);
      check("abort_words_left", 64'(exp_a.size()), 64'h0);

      // Restart after abort begins at index 0; a second start mid-dump is ignored
      out_ready_a = 1'b1;
      push_a(0, 31);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_word_a(5, "restart_wait_reg5");
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_done_a("restart_wait_done");
      for (int k = 0; k < 4; k++) tick();
      check("restart_words_left", 64'(exp_a.size()), 64'h0);
      check("restart_done_count", 64'(done_cnt_a), 64'h1);
      check("restart_idle_busy", 64'(busy_a), 64'h0);

      // Sub-range instance: indices 8..11 only
      for (int i = 8; i <= 11; i++) exp_b.push_back({5'(i), reg_val(i)});
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int k = 0; k < 20; k++) tick();
      check("b_word_count", 64'(words_b), 64'h4);
      check("b_words_left", 64'(exp_b.size()), 64'h0);
      check("b_done_count", 64'(done_cnt_b), 64'h1);

      // Asynchronous reset mid-SEND
      done_cnt_a = 0;
      push_a(0, 31);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      out_ready_a = 1'b0;
      wait_word_a(0, "rst_wait_send");
      #1;
      reset = 1'b1;
      #1;
      check("arst_valid", 64'(out_valid_a), 64'h0);
      check("arst_busy", 64'(busy_a), 64'h0);
      check("arst_done", 64'(done_a), 64'h0);
      check("arst_rd_addr", 64'(rd_addr_a), 64'h0);
      exp_a.delete();
      tick();
      reset = 1'b0;
      out_ready_a = 1'b1;
      for (int k = 0; k < 4; k++) tick();
      check("arst_stays_idle", 64'(busy_a), 64'h0);
      check("arst_done_count", 64'(done_cnt_a), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/reg_dump_reader.md
Name: reg_dump_reader

Overview:
- Read-side controller for the 32x32 register bank: on command, walks register addresses sequentially, samples each read port value, and streams (index, data) words out over a valid/ready interface.
- Sits between the register bank's second read port and a debug/trace sink (UART or memory-mapped dump buffer).
- While busy, top-level muxing gives it ownership of the read address.

Parameters:
- NUM_REGS, 32, number of registers dumped (1..32).
- FIRST_REG, 0, first register index dumped; FIRST_REG+NUM_REGS must be <= 32.
- DATA_W, 32, register data width.
- ADDR_W, 5, register address width.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle dump request; sampled only in IDLE.
- abort  input  1  cancel dump; takes priority over all other inputs except reset.
- rd_addr  output  ADDR_W  address driven to the register bank read port.
- rd_data  input  DATA_W  combinational read data returned for rd_addr.
- out_valid  output  1  out_data/out_index hold a word.
- out_ready  input  1  sink accepts the word.
- out_data  output  DATA_W  captured register value.
- out_index  output  ADDR_W  register index of out_data.
- busy  output  1  high in READ and SEND.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; rd_addr=0, out_valid=0, out_data=0, out_index=0, busy=0, done=0; internal index counter=0.
- States: IDLE, READ, SEND, DONE. All outputs are registered except busy, which is decoded from state.
- IDLE:
  - When start=1 and abort=0, go to READ, load counter=FIRST_REG, and drive rd_addr=FIRST_REG.
  - Otherwise remain in IDLE; rd_addr holds its last value.
- READ (exactly 1 cycle):
  - rd_addr = counter. At the clock edge, capture out_data<=rd_data and out_index<=counter, set out_valid<=1, go to SEND.
- SEND:
  - Hold out_valid, out_data and out_index stable until out_valid&&out_ready at a rising edge.
  - On transfer, clear out_valid.
  - If counter==FIRST_REG+NUM_REGS-1, go to DONE. Otherwise increment counter, update rd_addr, go to READ.
  - out_valid is never withdrawn without a transfer, except on abort or reset.
- DONE (exactly 1 cycle): done=1, then return to IDLE. done=0 in every other state.
- Latency:
  - start in cycle 0 -> READ in cycle 1 -> out_valid=1 from cycle 2.
  - With out_ready held high, words appear every 2 cycles.
  - A full 32-register dump runs start -> done in 2*NUM_REGS+1 cycles after the start edge (65 for the default).
- start while busy or in DONE is ignored; it is neither queued nor restarts the dump.
- abort=1 in any state: next edge goes to IDLE, clears out_valid, and does not pulse done. A partially delivered word is dropped.
- start and abort asserted together in IDLE: abort wins, state stays IDLE.
- Write collision: if the register bank writes the address being read in the READ cycle, the captured value is the pre-write contents. The bank updates on the same edge, so the dump is a coherent snapshot only if the core is stalled.
- Register 0 is dumped like any other; it reads as 0 because the bank never writes it.
- Counter arithmetic is ADDR_W bits. The last-index compare prevents wrap, so FIRST_REG=0, NUM_REGS=32 ends at index 31.
- Asserting reset mid-dump drops everything immediately; the next dump must be started again.

Test Plan:
- Reset, then preload bank reg[i]=0x1000_0000+i (reg0=0), hold out_ready=1, pulse start -> 32 words with indices 0..31, data 0x00000000, 0x10000001..0x1000001F; out_valid on cycles 2,4,...,64 after start; done pulses exactly once, at cycle 65; busy high cycles 1..64.
- Backpressure: out_ready low for 5 cycles while the word for reg3 is presented -> out_valid, out_data=0x10000003 and out_index=3 stay stable all 5 cycles; reg4 is presented only after the transfer, with no words lost or duplicated.
- abort asserted in SEND at index 10 -> next cycle state=IDLE, out_valid=0, busy=0, no done pulse. A new start then restarts from index 0.
- start pulsed again at index 5 of a running dump -> ignored; exactly 32 words and one done pulse.
- Params FIRST_REG=8, NUM_REGS=4 -> words with indices 8,9,10,11 only, then done. Separately, assert reset mid-SEND -> out_valid, busy and done all 0 asynchronously, before the next clock edge.
